// File: rtl/ariane_wakeup_ctrl_if.sv
// Bus bundle for ariane_wakeup_ctrl. The master drives the L1.5 return and
// soft-reset request. The slave drives the core reset, init-done and state.
interface ariane_wakeup_ctrl_if;
    logic       l15_val_i;
    logic       l15_int_ret_i;
    logic       soft_rst_req_i;
    logic       core_rst_no;
    logic       init_done_o;
    logic [1:0] state_o;

    modport master (
        output l15_val_i,
        output l15_int_ret_i,
        output soft_rst_req_i,
        input  core_rst_no,
        input  init_done_o,
        input  state_o
    );

    modport slave (
        input  l15_val_i,
        input  l15_int_ret_i,
        input  soft_rst_req_i,
        output core_rst_no,
        output init_done_o,
        output state_o
    );
endinterface

// File: rtl/ariane_wakeup_ctrl.sv
// Reset and wake-up sequencer for an Ariane tile.
// After rst_ni is released, the core stays in reset for InitCycles cycles so
// the tile SRAMs can initialize. The core also stays in reset during a
// HoldCycles-long soft reset.
// Optional macro WAKEUP_ON_INT_EN: the core is also held until an L1.5
// interrupt-return wake-up packet has been seen.
module ariane_wakeup_ctrl #(
    parameter int unsigned InitCycles = 32768,
    parameter int unsigned HoldCycles = 16,
    parameter int unsigned CntWidth   =
        $clog2(((InitCycles > HoldCycles) ? InitCycles : HoldCycles) + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    ariane_wakeup_ctrl_if.slave   bus
);

    localparam logic [1:0] StInit    = 2'd0;
`ifdef WAKEUP_ON_INT_EN
    localparam logic [1:0] StWaitInt = 2'd1;
`endif
    localparam logic [1:0] StRun     = 2'd2;
    localparam logic [1:0] StSoftRst = 2'd3;

    localparam logic [CntWidth-1:0] InitLast = CntWidth'(InitCycles - 1);
    localparam logic [CntWidth-1:0] HoldLast = CntWidth'(HoldCycles - 1);

    // Both waits need at least one cycle.
    if (InitCycles < 1) begin : g_bad_init
        $error("ariane_wakeup_ctrl: InitCycles must be >= 1");
    end
    if (HoldCycles < 1) begin : g_bad_hold
        $error("ariane_wakeup_ctrl: HoldCycles must be >= 1");
    end

    logic [1:0]          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic                core_rst_q;

`ifdef WAKEUP_ON_INT_EN
    logic wake_seen_q, wake_seen_d;
    logic wake_ev_c;

    // A wake-up needs a valid L1.5 return of type INT_RET.
    assign wake_ev_c = bus.l15_val_i & bus.l15_int_ret_i;
`else
    logic unused_l15_c;

    assign unused_l15_c = bus.l15_val_i ^ bus.l15_int_ret_i;
`endif

    // Next-state, counter and sticky-flag logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
`ifdef WAKEUP_ON_INT_EN
        wake_seen_d = wake_seen_q;
`endif
        case (state_q)
            StInit: begin
                cnt_d = cnt_q + CntWidth'(1);
`ifdef WAKEUP_ON_INT_EN
                wake_seen_d = wake_seen_q | wake_ev_c;
`endif
                if (cnt_q == InitLast) begin
                    cnt_d       = '0;
                    init_done_d = 1'b1;
`ifdef WAKEUP_ON_INT_EN
                    state_d = (wake_seen_q | wake_ev_c) ? StRun : StWaitInt;
`else
                    state_d = StRun;
`endif
                end
            end
`ifdef WAKEUP_ON_INT_EN
            StWaitInt: begin
                if (wake_ev_c) begin
                    state_d = StRun;
                end
            end
`endif
            StRun: begin
                if (bus.soft_rst_req_i) begin
                    state_d = StSoftRst;
                    cnt_d   = '0;
                end
            end
            StSoftRst: begin
                cnt_d = cnt_q + CntWidth'(1);
                if (cnt_q == HoldLast) begin
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers. The core reset tracks the next state, so it is high
    // exactly while the FSM is in RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StInit;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            core_rst_q  <= 1'b0;
`ifdef WAKEUP_ON_INT_EN
            wake_seen_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            core_rst_q  <= (state_d == StRun);
`ifdef WAKEUP_ON_INT_EN
            wake_seen_q <= wake_seen_d;
`endif
        end
    end

    assign bus.core_rst_no = core_rst_q;
    assign bus.init_done_o = init_done_q;
    assign bus.state_o     = state_q;

endmodule
